fir_capture_ram: RTL and testbench
==================================

# fir_capture_ram

Sample-capture block for the adaptive FIR datapath; the write-side counterpart of the sample ROMs that feed the filter. After an arm pulse it discards a programmable number of pipeline-latency samples. It then writes the next 2**NB_DEPTH filter outputs into internal RAM. Once full, it streams the buffer out over a valid/ready port for comparison against the golden output file or for export.

## Interface
- NB_DATA, 21, sample width (signed, two's complement; NBF_DATA fraction bits are not interpreted here)
- NB_DEPTH, 14, log2 of capture depth; buffer holds 2**NB_DEPTH words
- LATENCY, 3, number of valid samples discarded after arm, range 0..255
- i_clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_start  in  1  arm pulse; honoured only in IDLE
- i_sample  in  NB_DATA  filter output sample
- i_sample_valid  in  1  i_sample is a new sample this cycle
- i_rd_start  in  1  begin readout; honoured only in FULL
- i_rd_ready  in  1  consumer accepts o_rd_data this cycle
- o_rd_data  out  NB_DATA  readout word
- o_rd_valid  out  1  o_rd_data valid
- o_rd_last  out  1  qualifies the final word (address 2**NB_DEPTH-1)
- o_busy  out  1  state is SKIP or CAPTURE
- o_full  out  1  state is FULL
- o_count  out  NB_DEPTH+1  words written in current capture

## Operation
- States: IDLE, SKIP, CAPTURE, FULL, READOUT.
- IDLE: i_start -> clear wr_ptr and o_count, load skip_cnt=LATENCY. Go to SKIP, or to CAPTURE if LATENCY==0.
- SKIP: each i_sample_valid decrements skip_cnt; the valid that brings skip_cnt to 0 is discarded, then go to CAPTURE.
- CAPTURE: each i_sample_valid writes mem[wr_ptr]=i_sample, increments wr_ptr and o_count. The write at wr_ptr==2**NB_DEPTH-1 goes to FULL; wr_ptr wraps to 0, o_count ends at 2**NB_DEPTH.
- FULL: hold; i_rd_start -> READOUT, rd_ptr=0. i_start ignored.
- READOUT: fetch when words remain and (!o_rd_valid || i_rd_ready).
  - A fetch registers mem[rd_ptr] into o_rd_data, sets o_rd_valid, and sets o_rd_last if rd_ptr is the last address, then increments rd_ptr.
  - Without a fetch, i_rd_ready clears o_rd_valid.
  - Handshake on the o_rd_last word -> IDLE; o_rd_valid and o_rd_last clear on that edge.
- o_rd_data and o_rd_last are stable while o_rd_valid && !i_rd_ready.
- i_start outside IDLE and i_rd_start outside FULL are ignored (no error flag).
- i_sample is ignored outside SKIP/CAPTURE.
- Reset (any state, any time): state IDLE, pointers and counters 0. RAM contents are not cleared; a new capture overwrites them.

## Timing
- Reset values: o_rd_data=0, o_rd_valid=0, o_rd_last=0, o_busy=0, o_full=0, o_count=0.
- i_start sampled at edge E: o_busy high after E.
- A sample with i_sample_valid at edge E is written at E; o_count reflects it after E.
- o_full rises on the edge performing the last write.
- i_rd_start sampled at edge E: first o_rd_valid after edge E+1 (2-cycle latency).
- With i_rd_ready held high: one word per cycle, no bubbles; full readout takes 2**NB_DEPTH+1 cycles after i_rd_start.
- i_start and i_rd_start are level-sampled; holding them high re-arms only from the correct state.
- Back-to-back: IDLE is reached after the last handshake; i_start on the next edge is accepted.

## Structure
- Package fir_capture_pkg: state enum (3-bit localparams), default NB_DATA/NB_DEPTH/LATENCY.
- Sub-module fir_capture_mem: simple dual-port RAM, 2**NB_DEPTH x NB_DATA.
  - Write port: synchronous, single write-enable.
  - Read port: synchronous with read-enable, output register acts as o_rd_data.
  - No reset on the array.
- Top holds the FSM, skip counter, pointers, o_count and the valid/last flags.

## Test plan
- Basic capture: NB_DEPTH=4, LATENCY=3, i_start then ramp 0..20 valid every cycle -> words 3..18 stored, o_full after 19th sample, o_count=16.
- Gapped input: i_sample_valid every third cycle -> same stored data as the basic case. Invalid cycles change nothing.
- LATENCY=0: i_start then first sample 0x1FFFFF (-1) -> stored at address 0, skip state never entered.
- Readout backpressure: i_rd_ready random 50% -> 16 words in order, o_rd_data held while stalled, o_rd_last only on word 15, IDLE after its handshake.
- Ignored controls: i_start during CAPTURE and FULL, i_rd_start during CAPTURE -> no state or count change.
- Reset mid-op: drop i_rst during CAPTURE (o_count=7) and during READOUT -> all outputs at reset values. A fresh capture afterwards reads back correctly.

Source files
------------

// File: rtl/fir_capture_pkg.sv
// Shared definitions for the FIR output capture buffer.
//   - Default widths/depth/latency for fir_capture_ram.
//   - Capture FSM state encoding.
package fir_capture_pkg;

  localparam int unsigned NB_DATA_DEF  = 21;
  localparam int unsigned NB_DEPTH_DEF = 14;
  localparam int unsigned LATENCY_DEF  = 3;

  // Capture FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SKIP    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FULL    = 3'd3,
    ST_READOUT = 3'd4
  } state_t;

endpackage

// File: rtl/fir_capture_mem.sv
// Simple dual-port capture RAM, 2**NB_DEPTH x NB_DATA.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : async active-low reset, clears only the read output register
//   wr_en    : write strobe, writes wr_data at wr_addr
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe, loads mem[rd_addr] into rd_data
//   rd_addr  : read address
//   rd_data  : registered read data (holds when rd_en is low)
module fir_capture_mem #(
  parameter int unsigned NB_DATA  = 21,
  parameter int unsigned NB_DEPTH = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [NB_DEPTH-1:0] wr_addr,
  input  logic [NB_DATA-1:0]  wr_data,
  input  logic                rd_en,
  input  logic [NB_DEPTH-1:0] rd_addr,
  output logic [NB_DATA-1:0]  rd_data
);

  localparam int unsigned DEPTH = 1 << NB_DEPTH;

  logic [NB_DATA-1:0] mem [DEPTH];

  // Write port; the array itself is never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port; output register holds the last fetched word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fir_capture_ram.sv
// Capture buffer for the adaptive FIR output: after an arm pulse it drops
// LATENCY valid samples, stores the next 2**NB_DEPTH samples, then streams
// them out over a valid/ready port.
// Ports:
//   i_clk, i_rst        : clock, async active-low reset
//   i_start             : arm pulse (IDLE only)
//   i_sample(_valid)    : filter output sample and its qualifier
//   i_rd_start          : begin readout (FULL only)
//   i_rd_ready          : consumer accepts o_rd_data
//   o_rd_data/valid/last: readout stream, last marks the final address
//   o_busy              : skipping or capturing
//   o_full              : buffer complete, waiting for readout
//   o_count             : words written in the current capture
module fir_capture_ram
  import fir_capture_pkg::*;
#(
  parameter int unsigned NB_DATA  = NB_DATA_DEF,
  parameter int unsigned NB_DEPTH = NB_DEPTH_DEF,
  parameter int unsigned LATENCY  = LATENCY_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NB_DATA-1:0]  i_sample,
  input  logic                i_sample_valid,
  input  logic                i_rd_start,
  input  logic                i_rd_ready,
  output logic [NB_DATA-1:0]  o_rd_data,
  output logic                o_rd_valid,
  output logic                o_rd_last,
  output logic                o_busy,
  output logic                o_full,
  output logic [NB_DEPTH:0]   o_count
);

  localparam int unsigned NB_CNT  = NB_DEPTH + 1;
  localparam int unsigned NB_SKIP = 8;

  localparam logic [NB_DEPTH-1:0] LAST_ADDR = '1;

  state_t state;
  state_t next_state;

  logic [NB_DEPTH-1:0] wr_ptr;
  // Extra MSB flags that every word has been fetched
  logic [NB_DEPTH:0]   rd_ptr;
  logic [NB_SKIP-1:0]  skip_cnt;

  logic arm;
  logic skip_dec;
  logic wr_en;
  logic rd_load;
  logic fetch;
  logic pop;

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          next_state = (LATENCY == 0) ? ST_CAPTURE : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (i_sample_valid && (skip_cnt == NB_SKIP'(1))) begin
          next_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (i_sample_valid && (wr_ptr == LAST_ADDR)) begin
          next_state = ST_FULL;
        end
      end
      ST_FULL: begin
        if (i_rd_start) begin
          next_state = ST_READOUT;
        end
      end
      ST_READOUT: begin
        if (o_rd_valid && o_rd_last && i_rd_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    arm      = 1'b0;
    skip_dec = 1'b0;
    wr_en    = 1'b0;
    rd_load  = 1'b0;
    fetch    = 1'b0;
    pop      = 1'b0;
    case (state)
      ST_IDLE:    arm      = i_start;
      ST_SKIP:    skip_dec = i_sample_valid;
      ST_CAPTURE: wr_en    = i_sample_valid;
      ST_FULL:    rd_load  = i_rd_start;
      ST_READOUT: begin
        fetch = !rd_ptr[NB_DEPTH] && (!o_rd_valid || i_rd_ready);
        pop   = o_rd_valid && i_rd_ready;
      end
      default: ;
    endcase
  end

  // Pointers, counters and readout flags
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      skip_cnt   <= '0;
      o_count    <= '0;
      o_rd_valid <= 1'b0;
      o_rd_last  <= 1'b0;
      o_busy     <= 1'b0;
      o_full     <= 1'b0;
    end else begin
      if (arm) begin
        wr_ptr   <= '0;
        o_count  <= '0;
        skip_cnt <= NB_SKIP'(LATENCY);
      end
      if (skip_dec) begin
        skip_cnt <= skip_cnt - NB_SKIP'(1);
      end
      if (wr_en) begin
        wr_ptr  <= wr_ptr + NB_DEPTH'(1);
        o_count <= o_count + NB_CNT'(1);
      end
      if (rd_load) begin
        rd_ptr <= '0;
      end
      // A fetch replaces the word being handed over; otherwise a handshake empties the slot
      if (fetch) begin
        rd_ptr     <= rd_ptr + NB_CNT'(1);
        o_rd_valid <= 1'b1;
        o_rd_last  <= (rd_ptr[NB_DEPTH-1:0] == LAST_ADDR);
      end else if (pop) begin
        o_rd_valid <= 1'b0;
        o_rd_last  <= 1'b0;
      end
      o_busy <= (next_state == ST_SKIP) || (next_state == ST_CAPTURE);
      o_full <= (next_state == ST_FULL);
    end
  end

  fir_capture_mem #(
    .NB_DATA  (NB_DATA),
    .NB_DEPTH (NB_DEPTH)
  ) u_mem (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (i_sample),
    .rd_en   (fetch),
    .rd_addr (rd_ptr[NB_DEPTH-1:0]),
    .rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_fir_capture_ram.sv
// Self-checking bench for fir_capture_ram: two instances (LATENCY=3 and
// LATENCY=0, both 16 words deep) checked against a queue-based model of
// which samples land in the buffer and in what order they come back.
module tb_fir_capture_ram;

  localparam int unsigned NB_DATA  = 21;
  localparam int unsigned NB_DEPTH = 4;
  localparam int unsigned DEPTH    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]              start;
  logic [1:0]              sample_valid;
  logic [1:0]              rd_start;
  logic [1:0]              rd_ready;
  logic [1:0][NB_DATA-1:0] sample;

  wire [1:0][NB_DATA-1:0]  rd_data;
  wire [1:0]               rd_valid;
  wire [1:0]               rd_last;
  wire [1:0]               busy;
  wire [1:0]               full;
  wire [1:0][NB_DEPTH:0]   count;

  int n_checks = 0;
  int n_err    = 0;

  logic [NB_DATA-1:0] exp_q [$];

  always #5 clk = ~clk;

  fir_capture_ram #(.NB_DATA(NB_DATA), .NB_DEPTH(NB_DEPTH), .LATENCY(3)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start[0]), .i_sample(sample[0]),
    .i_sample_valid(sample_valid[0]), .i_rd_start(rd_start[0]), .i_rd_ready(rd_ready[0]),
    .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]), .o_rd_last(rd_last[0]),
    .o_busy(busy[0]), .o_full(full[0]), .o_count(count[0])
  );

  fir_capture_ram #(.NB_DATA(NB_DATA), .NB_DEPTH(NB_DEPTH), .LATENCY(0)) dut_l0 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start[1]), .i_sample(sample[1]),
    .i_sample_valid(sample_valid[1]), .i_rd_start(rd_start[1]), .i_rd_ready(rd_ready[1]),
    .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]), .o_rd_last(rd_last[1]),
    .o_busy(busy[1]), .o_full(full[1]), .o_count(count[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int k);
    chk("rst_rd_data",  32'(rd_data[k]),  32'd0);
    chk("rst_rd_valid", 32'(rd_valid[k]), 32'd0);
    chk("rst_rd_last",  32'(rd_last[k]),  32'd0);
    chk("rst_busy",     32'(busy[k]),     32'd0);
    chk("rst_full",     32'(full[k]),     32'd0);
    chk("rst_count",    32'(count[k]),    32'd0);
  endtask

  // mode 0: ramp every cycle; 1: ramp every third cycle with ignored
  // controls injected; 2: random data/valid; 3: all-ones first, then random
  task automatic capture(input int k, input int lat, input int mode, input int n_in);
    int nv = 0;
    int vi = 0;
    logic v;
    logic [NB_DATA-1:0] s;
    exp_q.delete();
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    chk("arm_busy",  32'(busy[k]),  32'd1);
    chk("arm_full",  32'(full[k]),  32'd0);
    chk("arm_count", 32'(count[k]), 32'd0);
    for (int cyc = 0; cyc < 400 && vi < n_in; cyc++) begin
      start[k]    = 1'b0;
      rd_start[k] = 1'b0;
      case (mode)
        0: begin v = 1'b1; s = NB_DATA'(vi); end
        1: begin
          v = (cyc % 3 == 2);
          s = v ? NB_DATA'(vi) : NB_DATA'($urandom);
          if (!v && exp_q.size() == 5) begin
            start[k]    = 1'b1;
            rd_start[k] = 1'b1;
          end
        end
        3: begin
          v = (vi == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          s = (vi == 0) ? '1 : NB_DATA'($urandom);
        end
        default: begin v = ($urandom_range(0, 3) != 0); s = NB_DATA'($urandom); end
      endcase
      sample_valid[k] = v;
      sample[k]       = s;
      if (v) begin
        if (nv >= lat && exp_q.size() < DEPTH) exp_q.push_back(s);
        nv++;
        vi++;
      end
      tick();
      chk("cap_count", 32'(count[k]), 32'(exp_q.size()));
      chk("cap_full",  32'(full[k]),  32'(exp_q.size() == DEPTH));
      chk("cap_busy",  32'(busy[k]),  32'(exp_q.size() < DEPTH));
    end
    start[k]        = 1'b0;
    rd_start[k]     = 1'b0;
    sample_valid[k] = 1'b0;
    chk("cap_budget", 32'(vi), 32'(n_in));
  endtask

  task automatic readout(input int k);
    int idx = 0;
    logic pv, pl, pr;
    logic [NB_DATA-1:0] pd;
    rd_start[k] = 1'b1;
    tick();
    rd_start[k] = 1'b0;
    chk("rd_start_valid", 32'(rd_valid[k]), 32'd0);
    chk("rd_start_full",  32'(full[k]),     32'd0);
    for (int cyc = 0; cyc < 200 && idx < DEPTH; cyc++) begin
      pv = rd_valid[k];
      pd = rd_data[k];
      pl = rd_last[k];
      pr = 1'($urandom_range(0, 1));
      rd_ready[k] = pr;
      tick();
      if (cyc == 0) chk("rd_first_valid", 32'(rd_valid[k]), 32'd1);
      if (pv && pr) begin
        chk("rd_data", 32'(pd), 32'(exp_q[idx]));
        chk("rd_last", 32'(pl), 32'(idx == DEPTH - 1));
        idx++;
      end else if (pv) begin
        chk("stall_valid", 32'(rd_valid[k]), 32'd1);
        chk("stall_data",  32'(rd_data[k]),  32'(pd));
        chk("stall_last",  32'(rd_last[k]),  32'(pl));
      end
    end
    rd_ready[k] = 1'b0;
    chk("rd_words",     32'(idx),         32'(DEPTH));
    chk("rd_end_valid", 32'(rd_valid[k]), 32'd0);
    chk("rd_end_last",  32'(rd_last[k]),  32'd0);
    chk("rd_end_full",  32'(full[k]),     32'd0);
    chk("rd_end_busy",  32'(busy[k]),     32'd0);
  endtask

  initial begin
    start        = '0;
    sample_valid = '0;
    rd_start     = '0;
    rd_ready     = '0;
    sample       = '0;

    // Reset state
    repeat (3) tick();
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    tick();

    // Basic ramp capture, start ignored in FULL, readout with backpressure
    capture(0, 3, 0, 21);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("full_ign_busy",  32'(busy[0]),  32'd0);
    chk("full_ign_full",  32'(full[0]),  32'd1);
    chk("full_ign_count", 32'(count[0]), 32'd16);
    readout(0);

    // Gapped ramp with ignored start/rd_start during CAPTURE
    capture(0, 3, 1, 21);
    readout(0);

    // Random data and valid pattern
    capture(0, 3, 2, 21);
    readout(0);

    // Zero latency: first sample lands at address 0
    capture(1, 0, 3, 18);
    readout(1);

    // Reset during CAPTURE at count 7
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample[0]       = NB_DATA'(i);
      sample_valid[0] = 1'b1;
      tick();
    end
    sample_valid[0] = 1'b0;
    chk("mid_count", 32'(count[0]), 32'd7);
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset(0);

    // Reset during READOUT
    capture(0, 3, 2, 21);
    rd_start[0] = 1'b1;
    tick();
    rd_start[0] = 1'b0;
    rd_ready[0] = 1'b1;
    repeat (3) tick();
    chk("mid_rd_valid", 32'(rd_valid[0]), 32'd1);
    rd_ready[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh capture after reset
    capture(0, 3, 2, 21);
    readout(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
